// File: rtl/port_rd_pkg.sv
// rtl/port_rd_pkg.sv - shared types and constants for the per-port read sequencer
package port_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_CELL = 2'd2,
        ST_DONE = 2'd3
    } rd_seq_state_t;

    localparam logic [3:0] PRIO_NONE = 4'd8;
    localparam int         QUEUE_NUM = 8;

    typedef logic [2:0] qid_t;

endpackage

// File: rtl/rd_credit_counter.sv
// rtl/rd_credit_counter.sv - saturating output-credit counter; simultaneous return and spend cancel
module rd_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic has_credit
);

    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0] credit;
    logic [CW-1:0] credit_nxt;

    always_comb begin
        credit_nxt = credit;
        if (inc && !dec && credit != CW'(CREDITS)) begin
            credit_nxt = credit + CW'(1);
        end else if (dec && !inc && credit != '0) begin
            credit_nxt = credit - CW'(1);
        end
    end

    // Looks at the post-event count so a registered request never outruns the credit.
    assign has_credit = (credit_nxt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CW'(CREDITS);
        end else begin
            credit <= credit_nxt;
        end
    end

endmodule

// File: rtl/port_rd_sequencer.sv
// rtl/port_rd_sequencer.sv - picks the scheduler's queue, fetches head length, issues per-cell SRAM reads
module port_rd_sequencer
    import port_rd_pkg::*;
#(
    parameter int SETTLE_CYC = 6,
    parameter int LEN_W      = 7,
    parameter int CREDITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 port_en,
    input  logic [QUEUE_NUM-1:0] queue_empty,
    input  logic [3:0]           prior_next,
    output logic                 prior_update,
    output logic                 head_req,
    output logic [2:0]           head_queue,
    input  logic                 head_ack,
    input  logic [LEN_W-1:0]     head_len,
    output logic                 cell_req,
    output logic [2:0]           cell_queue,
    output logic                 cell_last,
    input  logic                 cell_gnt,
    input  logic                 cell_done,
    output logic                 busy,
    output logic [15:0]          pkt_cnt,
    output logic                 err_zero_len
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    rd_seq_state_t    state, state_n;
    qid_t             sel_q;
    logic [LEN_W-1:0] remain, remain_n;
    logic [SW-1:0]    settle;
    logic             eligible;
    logic             accepted;
    logic             has_credit;

    assign accepted   = cell_req && cell_gnt;
    assign head_queue = sel_q;
    assign cell_queue = sel_q;

    rd_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .inc        (cell_done),
        .dec        (accepted),
        .has_credit (has_credit)
    );

    always_comb begin
        state_n  = state;
        remain_n = remain;
        eligible = 1'b0;
        case (state)
            ST_IDLE: begin
                if (port_en && settle == '0 && prior_next < PRIO_NONE
                    && !queue_empty[prior_next[2:0]]) begin
                    eligible = 1'b1;
                    state_n  = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (head_ack) begin
                    if (head_len == '0) begin
                        state_n = ST_IDLE;
                    end else begin
                        remain_n = head_len;
                        state_n  = ST_CELL;
                    end
                end
            end
            ST_CELL: begin
                if (accepted) begin
                    remain_n = remain - LEN_W'(1);
                    if (remain == LEN_W'(1)) begin
                        state_n = ST_DONE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            sel_q        <= '0;
            remain       <= '0;
            settle       <= SW'(SETTLE_CYC);
            prior_update <= 1'b0;
            head_req     <= 1'b0;
            cell_req     <= 1'b0;
            cell_last    <= 1'b0;
            busy         <= 1'b0;
            pkt_cnt      <= '0;
            err_zero_len <= 1'b0;
        end else begin
            state        <= state_n;
            remain       <= remain_n;
            prior_update <= eligible;
            head_req     <= (state_n == ST_HEAD);
            cell_req     <= (state_n == ST_CELL) && has_credit;
            cell_last    <= (state_n == ST_CELL) && (remain_n == LEN_W'(1));
            busy         <= (state_n != ST_IDLE);
            if (eligible) begin
                sel_q  <= prior_next[2:0];
                settle <= SW'(SETTLE_CYC);
            end else if (settle != '0) begin
                settle <= settle - SW'(1);
            end
            if (state == ST_DONE) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (state == ST_HEAD && head_ack && head_len == '0) begin
                err_zero_len <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_port_rd_sequencer.sv
// tb/tb_port_rd_sequencer.sv - scoreboard bench for port_rd_sequencer
module tb_port_rd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        port_en;
    logic [7:0]  queue_empty;
    logic [3:0]  prior_next;
    logic        prior_update;
    logic        head_req;
    logic [2:0]  head_queue;
    logic        head_ack;
    logic [6:0]  head_len;
    logic        cell_req;
    logic [2:0]  cell_queue;
    logic        cell_last;
    logic        cell_gnt;
    logic        cell_done;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic        err_zero_len;

    logic        auto_done;
    logic        man_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pu_cnt = 0;
    int gnt_cnt = 0;
    int pu_cyc[$];
    logic [2:0] exp_head[$];
    logic [3:0] exp_cell[$];
    logic [3:0] mon_e;

    assign cell_done = (auto_done & cell_req & cell_gnt) | man_done;

    port_rd_sequencer #(
        .SETTLE_CYC (6),
        .LEN_W      (7),
        .CREDITS    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_en      (port_en),
        .queue_empty  (queue_empty),
        .prior_next   (prior_next),
        .prior_update (prior_update),
        .head_req     (head_req),
        .head_queue   (head_queue),
        .head_ack     (head_ack),
        .head_len     (head_len),
        .cell_req     (cell_req),
        .cell_queue   (cell_queue),
        .cell_last    (cell_last),
        .cell_gnt     (cell_gnt),
        .cell_done    (cell_done),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt),
        .err_zero_len (err_zero_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (prior_update) begin
                pu_cnt++;
                pu_cyc.push_back(cyc);
            end
            if (head_req && head_ack) begin
                if (exp_head.size() == 0) check("pending_heads", exp_head.size(), 1);
                else check("head_queue", {29'd0, head_queue}, {29'd0, exp_head.pop_front()});
            end
            if (cell_req && cell_gnt) begin
                gnt_cnt++;
                if (exp_cell.size() == 0) begin
                    check("pending_cells", exp_cell.size(), 1);
                end else begin
                    mon_e = exp_cell.pop_front();
                    check("cell_queue", {29'd0, cell_queue}, {29'd0, mon_e[2:0]});
                    check("cell_last", {31'd0, cell_last}, {31'd0, mon_e[3]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_head(input string name);
        int n = 0;
        while (!head_req && n < 40) begin
            tick();
            n++;
        end
        check({name, "_head_req"}, {31'd0, head_req}, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic ack(input logic [6:0] len);
        head_ack = 1'b1;
        head_len = len;
        tick();
        head_ack = 1'b0;
        head_len = '0;
    endtask

    task automatic push_pkt(input logic [2:0] q, input int len);
        exp_head.push_back(q);
        for (int i = 1; i <= len; i++) exp_cell.push_back({(i == len), q});
    endtask

    initial begin
        int seen;
        rst = 1'b1; port_en = 1'b1; queue_empty = 8'hFF; prior_next = 4'd8;
        head_ack = 1'b0; head_len = '0; cell_gnt = 1'b1; auto_done = 1'b1; man_done = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and no selection while nothing is eligible
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_pkt_cnt", {16'd0, pkt_cnt}, 0);
        check("rst_err", {31'd0, err_zero_len}, 0);
        check("rst_cell_req", {31'd0, cell_req}, 0);
        check("rst_head_queue", {29'd0, head_queue}, 0);
        check("rst_credit", {29'd0, dut.u_credit.credit}, 4);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (head_req || busy || prior_update) seen++;
        end
        check("idle_quiet", seen, 0);

        // Basic 3-cell packet from queue 2
        push_pkt(3'd2, 3);
        prior_next = 4'd2; queue_empty = 8'hFB;
        wait_head("p1");
        prior_next = 4'd8; queue_empty = 8'hFF;
        tick(); tick();
        check("p1_head_hold", {31'd0, head_req}, 1);
        ack(7'd3);
        wait_idle("p1");
        check("p1_pkt_cnt", {16'd0, pkt_cnt}, 1);
        check("p1_pu_cnt", pu_cnt, 1);

        // 6-cell packet with credit exhaustion
        gnt_cnt = 0; auto_done = 1'b0;
        push_pkt(3'd1, 6);
        prior_next = 4'd1; queue_empty = 8'hFD;
        wait_head("p2");
        prior_next = 4'd8; queue_empty = 8'hFF;
        ack(7'd6);
        for (int i = 0; i < 12; i++) tick();
        check("p2_gnt_stall", gnt_cnt, 4);
        check("p2_req_low", {31'd0, cell_req}, 0);
        check("p2_busy", {31'd0, busy}, 1);
        for (int k = 0; k < 2; k++) begin
            man_done = 1'b1; tick(); man_done = 1'b0;
            for (int i = 0; i < 3; i++) tick();
        end
        wait_idle("p2");
        check("p2_gnt_total", gnt_cnt, 6);
        check("p2_pkt_cnt", {16'd0, pkt_cnt}, 2);
        for (int k = 0; k < 6; k++) begin
            man_done = 1'b1; tick(); man_done = 1'b0; tick();
        end
        check("credit_saturate", {29'd0, dut.u_credit.credit}, 4);
        auto_done = 1'b1;

        // Zero-length head, then a normal packet from the same queue
        exp_head.push_back(3'd3);
        prior_next = 4'd3; queue_empty = 8'hF7;
        wait_head("z");
        prior_next = 4'd8;
        ack(7'd0);
        tick();
        check("z_err", {31'd0, err_zero_len}, 1);
        check("z_busy", {31'd0, busy}, 0);
        check("z_pkt_cnt", {16'd0, pkt_cnt}, 2);
        push_pkt(3'd3, 2);
        prior_next = 4'd3;
        wait_head("z2");
        prior_next = 4'd8; queue_empty = 8'hFF;
        ack(7'd2);
        wait_idle("z2");
        check("z2_pkt_cnt", {16'd0, pkt_cnt}, 3);
        check("z2_err_sticky", {31'd0, err_zero_len}, 1);

        // Back-to-back from queue 5: settle window spacing
        pu_cyc.delete();
        prior_next = 4'd5; queue_empty = 8'hDF;
        for (int k = 0; k < 2; k++) begin
            push_pkt(3'd5, 1);
            wait_head("b2b");
            if (k == 1) begin
                prior_next = 4'd8; queue_empty = 8'hFF;
            end
            ack(7'd1);
        end
        wait_idle("b2b");
        check("b2b_pu_count", pu_cyc.size(), 2);
        if (pu_cyc.size() == 2) check("b2b_pu_gap", pu_cyc[1] - pu_cyc[0], 7);
        check("b2b_pkt_cnt", {16'd0, pkt_cnt}, 5);

        // Reset in CELL with 3 cells remaining
        auto_done = 1'b0; cell_gnt = 1'b0;
        exp_head.push_back(3'd6);
        exp_cell.push_back({1'b0, 3'd6});
        exp_cell.push_back({1'b0, 3'd6});
        prior_next = 4'd6; queue_empty = 8'hBF;
        wait_head("r");
        prior_next = 4'd8; queue_empty = 8'hFF;
        ack(7'd5);
        check("r_cell_req", {31'd0, cell_req}, 1);
        cell_gnt = 1'b1; tick(); tick(); cell_gnt = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("r_busy", {31'd0, busy}, 0);
        check("r_cell_req_low", {31'd0, cell_req}, 0);
        check("r_head_req", {31'd0, head_req}, 0);
        check("r_pkt_cnt", {16'd0, pkt_cnt}, 0);
        check("r_err", {31'd0, err_zero_len}, 0);
        check("r_credit", {29'd0, dut.u_credit.credit}, 4);
        check("sb_cells_left", exp_cell.size(), 0);
        check("sb_heads_left", exp_head.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/port_rd_sequencer.md
# port_rd_sequencer

Per-port read sequencer sitting between the port's queue scheduler (WRR / strict-priority dispatcher) and the shared cell-SRAM read arbiter. It waits for the scheduler's `prior_next` to settle and selects the indicated non-empty queue. It fetches that queue's head-packet length, then issues one SRAM cell-read request per cell under output-credit backpressure. It pulses `prior_update` so the scheduler advances its round.

## Interface
- `SETTLE_CYC`, 6: cycles `prior_next` is ignored after each `prior_update` (covers the scheduler's worst-case mask/round update plus its output register).
- `LEN_W`, 7: width of packet length in cells.
- `CREDITS`, 4: maximum cells granted but not yet consumed by the port transmitter.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `port_en` in 1: port read enable.
- `queue_empty` in 8: per-queue empty flags, 1 = empty.
- `prior_next` in 4: scheduler's next queue; 0..7 valid, ≥8 = none.
- `prior_update` out 1: one-cycle pulse marking that the current `prior_next` was consumed.
- `head_req` out 1: head-length request, held until ack.
- `head_queue` out 3: queue being dequeued.
- `head_ack` in 1: head length valid this cycle.
- `head_len` in LEN_W: packet length in cells.
- `cell_req` out 1: cell-read request to the SRAM arbiter.
- `cell_queue` out 3: queue of the requested cell.
- `cell_last` out 1: the current request is the packet's final cell.
- `cell_gnt` in 1: arbiter accepted `cell_req` this cycle.
- `cell_done` in 1: port transmitter consumed one cell (returns one credit).
- `busy` out 1: a packet is in progress.
- `pkt_cnt` out 16: packets completed, wraps.
- `err_zero_len` out 1: sticky flag; cleared only by reset.

## Operation
- The FSM has four states: IDLE, HEAD, CELL, DONE. All outputs are registered.
- **IDLE:** the block is eligible when all of the following hold:
  - `port_en` = 1;
  - settle counter = 0;
  - `prior_next` < 8;
  - `queue_empty[prior_next]` = 0.
- **IDLE → HEAD** on eligibility:
  - latch `sel_q` = `prior_next[2:0]`;
  - next cycle, `prior_update` = 1 for exactly one cycle, `head_req` = 1, `head_queue` = `sel_q`;
  - settle counter loads `SETTLE_CYC`.
- **HEAD:** hold `head_req` until `head_ack`.
  - On ack with `head_len` = 0: set `err_zero_len` and go to IDLE; `pkt_cnt` is unchanged.
  - On ack otherwise: `remain` ← `head_len` and go to CELL.
- **CELL:** `cell_req` = 1 while credit > 0, else 0.
  - `cell_last` = (`remain` == 1).
  - On `cell_gnt` with `cell_req` = 1: `remain` decrements and credit decrements.
  - The grant that takes `remain` 1 → 0 moves the FSM to DONE.
  - A `cell_gnt` while `cell_req` = 0 is ignored.
- **DONE:** `pkt_cnt` increments (wraps 0xFFFF → 0), then IDLE.
- **Credit counter** (0..CREDITS, reset = CREDITS):
  - +1 on `cell_done`, −1 on an accepted grant;
  - both in the same cycle: unchanged;
  - `cell_done` at CREDITS saturates (no overflow).
- **Settle counter:** decrements to 0 and holds there.
- **`port_en` deasserted mid-packet:** the current packet completes; the FSM then stays in IDLE.
- **`queue_empty` / `prior_next` changes** are ignored outside IDLE.
- `busy` = 1 in HEAD, CELL and DONE.

## Timing
- Reset values:
  - FSM = IDLE; all request/pulse outputs = 0; `head_queue` = `cell_queue` = 0;
  - `pkt_cnt` = 0; `err_zero_len` = 0; credit = CREDITS; settle counter = `SETTLE_CYC`; `busy` = 0.
- Reset mid-packet: the next edge returns all state to reset values. Outstanding grants are dropped and the credit count is restored to CREDITS.
- Eligible in IDLE at cycle t: `prior_update` and `head_req` are high at t+1.
- Earliest next selection is t+1+`SETTLE_CYC`, or later if the packet is still in progress.
- `head_ack` at cycle a: first `cell_req` at a+1 (if credit > 0).
- With no backpressure, one cell is accepted per cycle: an N-cell packet occupies N CELL cycles, plus 1 DONE cycle.
- `cell_req`, `cell_queue` and `cell_last` stay stable until granted, unless credit is exhausted; in that case `cell_req` drops the cycle after credit reaches 0.

## Structure
- Shared package `port_rd_pkg`:
  - FSM state enum `rd_seq_state_t`;
  - `PRIO_NONE` = 4'd8;
  - `QUEUE_NUM` = 8;
  - queue-index type `qid_t` (3 bits).
- One sub-module, `rd_credit_counter`: saturating up/down counter with a simultaneous-event rule; parameter CREDITS; outputs `has_credit`.

## Test plan
- Reset; `queue_empty`=8'hFF, `prior_next`=8 → no `head_req` for 50 cycles, `busy`=0, credit=4.
- `prior_next`=2, `queue_empty`=8'hFB, `head_len`=3, `cell_gnt` tied high, `cell_done` each grant → one `prior_update` pulse; `head_queue`=2; 3 grants with `cell_last` on the 3rd; `pkt_cnt`=1.
- `head_len`=6, CREDITS=4, `cell_done` withheld → exactly 4 grants then `cell_req`=0; release 2 `cell_done` → 2 more grants, DONE.
- `head_len`=0 → `err_zero_len`=1, IDLE, `pkt_cnt` unchanged; the next valid packet proceeds normally.
- Back-to-back packets, queue 5 always non-empty → second `prior_update` no earlier than 7 cycles after the first (SETTLE_CYC=6).
- `rst` asserted in CELL with `remain`=3 → next cycle FSM=IDLE, `cell_req`=0, credit=4, `pkt_cnt`=0.
